// File: rtl/cordic_result_serializer.sv
// Result-pair buffer for cordic_system: stores (cos, sin) pairs in a small FIFO and
// replays them as a cos-then-sin word stream with frame marking and drop detection.
module cordic_result_serializer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 17
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iData_valid,
    input  logic [DATA_W-1:0]        iData_cos,
    input  logic [DATA_W-1:0]        iData_sin,
    output logic                     oReady,
    output logic                     oWord_valid,
    output logic [DATA_W-1:0]        oWord,
    output logic                     oWord_sel,
    output logic                     oLast,
    input  logic                     iWord_ready,
    output logic                     oOverflow,
    output logic [$clog2(DEPTH):0]   oFill
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] SCNT_LAST = SW'(FRAME_LEN - 1);

    logic [DATA_W-1:0] cosMem [DEPTH];
    logic [DATA_W-1:0] sinMem [DEPTH];

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   fill;
    logic          ph;
    logic [SW-1:0] scnt;
    logic          overflow;

    logic push;
    logic pop;
    logic xfer;
    logic drop;

    // Acceptance is decided from registered occupancy only; a same-cycle pop
    // never frees a slot for the incoming pair.
    assign oReady = (fill < FULL) && !iReset;
    assign push   = iData_valid && oReady;
    assign drop   = iData_valid && !oReady && !iReset;

    assign oWord_valid = (fill != '0);
    assign xfer        = oWord_valid && iWord_ready;
    assign pop         = xfer && ph;

    assign oWord     = !oWord_valid ? '0 : (ph ? sinMem[rdPtr] : cosMem[rdPtr]);
    assign oWord_sel = ph;
    assign oLast     = oWord_valid && ph && (scnt == SCNT_LAST);
    assign oOverflow = overflow;
    assign oFill     = fill;

    // Pair storage carries data only, so it is left out of reset.
    always_ff @(posedge iClk) begin
        if (push) begin
            cosMem[wrPtr] <= iData_cos;
            sinMem[wrPtr] <= iData_sin;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            fill     <= '0;
            ph       <= 1'b0;
            scnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (xfer) ph <= !ph;
            if (pop)  scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule
